// File: rtl/demux2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux2_stream
//  Description : 1-to-2 valid/ready stream demultiplexer. Each beat is routed
//                by in_sel into one of two independent DEPTH-entry FIFOs, so
//                a stalled consumer does not block traffic to the other one
//                while its FIFO still has room.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux2_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [WIDTH-1:0]         out1_data,
    output logic [$clog2(DEPTH):0]   cnt0,
    output logic [$clog2(DEPTH):0]   cnt1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Per-output status and handshake vectors, index 0 = out0, 1 = out1.
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    occ  [2];

    assign out_ready = {out1_ready, out0_ready};

    // Only the FIFO the current beat targets gates acceptance; the consumer
    // side never reaches in_ready combinationally.
    assign in_ready = reset_n & ~full[in_sel];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        localparam logic SEL = (g == 1);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt;

        assign full[g]  = (cnt == FULL_CNT);
        assign empty[g] = (cnt == '0);
        assign push[g]  = in_valid & in_ready & (in_sel == SEL);
        // A ready on an empty FIFO is ignored.
        assign pop[g]   = out_ready[g] & ~empty[g];
        assign head[g]  = mem[rd_ptr];
        assign occ[g]   = cnt;

        // Pointer and occupancy bookkeeping; pointers wrap naturally since
        // DEPTH is a power of two.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[g], pop[g]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage array; contents need no reset because occupancy gates use.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end

    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign cnt0       = occ[0];
    assign cnt1       = occ[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux2_stream
//  Description : Self-checking bench for demux2_stream using two queues as the
//                reference model of the output FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux2_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [$clog2(DEPTH):0] cnt0;
    logic [$clog2(DEPTH):0] cnt1;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and update the queue model from the inputs
    // presented before the edge. Returns 1 ns after the edge.
    task automatic cycle();
        bit               acc;
        bit               p0;
        bit               p1;
        bit               s;
        logic [WIDTH-1:0] d;
        acc = in_valid && (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        p0  = out0_ready && (q0.size() > 0);
        p1  = out1_ready && (q1.size() > 0);
        s   = in_sel;
        d   = in_data;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got=%b exp=0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got=%b exp=0", out1_valid); end
        checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
        checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_route();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hbeef;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready got=%b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL route_out0_valid got=%b exp=1", out0_valid); end
        checks++; if (out0_data !== 16'hbeef) begin errors++; $display("FAIL route_out0_data got=%h exp=beef", out0_data); end
        checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL route_cnt0 got=%0d exp=1", cnt0); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_valid got=%b exp=0", out1_valid); end
    endtask

    task automatic test_alternate();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hdead;
        cycle();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 16'hdead) begin errors++; $display("FAIL alt_out1_dead got=%b/%h exp=1/dead", out1_valid, out1_data); end
        in_sel = 1'b0; in_data = 16'habcd;
        cycle();
        in_valid = 1'b0;
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL alt_out1_gone got=%b exp=0", out1_valid); end
        checks++; if (out0_data !== 16'hbeef) begin errors++; $display("FAIL alt_out0_head got=%h exp=beef", out0_data); end
        checks++; if (cnt0 !== 2'd2) begin errors++; $display("FAIL alt_cnt0 got=%0d exp=2", cnt0); end
        cycle();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL alt_out1_stays_empty got=%b exp=0", out1_valid); end
    endtask

    task automatic test_full_stall();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        cycle();
        checks++; if (cnt0 !== 2'd2) begin errors++; $display("FAIL stall_cnt0 got=%0d exp=2", cnt0); end
        in_sel = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_in_ready got=%b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 16'h1234) begin errors++; $display("FAIL stall_out1 got=%b/%h exp=1/1234", out1_valid, out1_data); end
        checks++; if (cnt0 !== 2'd2 || out0_data !== 16'hbeef) begin errors++; $display("FAIL stall_out0_kept got=%0d/%h exp=2/beef", cnt0, out0_data); end
        out1_ready = 1'b1;
        cycle();
        out1_ready = 1'b0;
        checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL stall_drain_cnt1 got=%0d exp=0", cnt1); end
    endtask

    task automatic test_full_pop();
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5555;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refuse got=%b exp=0", in_ready); end
        cycle();
        checks++; if (cnt0 !== 2'd1 || out0_data !== 16'habcd) begin errors++; $display("FAIL fullpop_c1 got=%0d/%h exp=1/abcd", cnt0, out0_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_again got=%b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (cnt0 !== 2'd1 || out0_data !== 16'h5555) begin errors++; $display("FAIL fullpop_c2 got=%0d/%h exp=1/5555", cnt0, out0_data); end
        cycle();
        out0_ready = 1'b0;
        checks++; if (cnt0 !== 2'd0 || out0_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drain got=%0d/%b exp=0/0", cnt0, out0_valid); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] got[$];
        int               idx;
        idx = 0;
        out1_ready = 1'b0;
        for (int c = 0; c < 64 && got.size() < 8; c++) begin
            in_valid   = (idx < 8);
            in_sel     = 1'b0;
            in_data    = 16'(idx + 1);
            out0_ready = c[0];
            #1;
            checks++; if (in_ready !== (q0.size() < DEPTH)) begin errors++; $display("FAIL wrap_in_ready got=%b exp=%b", in_ready, q0.size() < DEPTH); end
            if (out0_valid && out0_ready) got.push_back(out0_data);
            if (in_valid && in_ready) idx++;
            cycle();
            checks++; if (cnt0 > 2'd2 || cnt0 !== 2'(q0.size())) begin errors++; $display("FAIL wrap_cnt0 got=%0d exp=%0d", cnt0, q0.size()); end
        end
        in_valid = 1'b0;
        out0_ready = 1'b0;
        checks++; if (got.size() != 8) begin errors++; $display("FAIL wrap_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, got[i], 16'(i + 1)); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_valid   = 1'($urandom);
            in_sel     = 1'($urandom);
            in_data    = 16'($urandom);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            #1;
            checks++; if (in_ready !== (in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH))) begin errors++; $display("FAIL rand_in_ready n=%0d got=%b", n, in_ready); end
            cycle();
            checks++; if (out0_valid !== (q0.size() > 0) || cnt0 !== 2'(q0.size())) begin errors++; $display("FAIL rand_out0 n=%0d got=%b/%0d exp=%0d", n, out0_valid, cnt0, q0.size()); end
            checks++; if (out1_valid !== (q1.size() > 0) || cnt1 !== 2'(q1.size())) begin errors++; $display("FAIL rand_out1 n=%0d got=%b/%0d exp=%0d", n, out1_valid, cnt1, q1.size()); end
            if (q0.size() > 0) begin
                checks++; if (out0_data !== q0[0]) begin errors++; $display("FAIL rand_out0_data n=%0d got=%h exp=%h", n, out0_data, q0[0]); end
            end
            if (q1.size() > 0) begin
                checks++; if (out1_data !== q1[0]) begin errors++; $display("FAIL rand_out1_data n=%0d got=%h exp=%h", n, out1_data, q1[0]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0a0a;
        cycle();
        in_sel = 1'b1; in_data = 16'h0b0b;
        cycle();
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin errors++; $display("FAIL areset_setup got=%b/%b exp=1/1", out0_valid, out1_valid); end
        in_sel = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b/%b exp=0/0", out0_valid, out1_valid); end
        checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h7777;
        cycle();
        in_valid = 1'b0;
        checks++; if (out0_data !== 16'h7777 || cnt0 !== 2'd1 || cnt1 !== 2'd0) begin errors++; $display("FAIL areset_first got=%h/%0d/%0d exp=7777/1/0", out0_data, cnt0, cnt1); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_alternate();
        test_full_stall();
        test_full_pop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 stream demultiplexer: the reverse of mux2.
- Routes one WIDTH-bit valid/ready input stream to one of two output streams, chosen per beat by a select bit.
- Each output has a DEPTH-entry FIFO, so one stalled consumer does not block beats bound for the other while there is room.
- Sits between a single producer and two independent consumers in the datapath.

Parameters:
WIDTH, 16, data width of every stream.
DEPTH, 2, entries per output FIFO; a power of 2 and at least 2.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer presents a beat.
in_ready  output  1  block accepts the beat this cycle.
in_sel  input  1  destination of the beat: 0 goes to out0, 1 goes to out1.
in_data  input  WIDTH  beat payload.
out0_valid  output  1  out0 FIFO is non-empty.
out0_ready  input  1  consumer 0 takes the head entry.
out0_data  output  WIDTH  out0 FIFO head entry.
out1_valid  output  1  out1 FIFO is non-empty.
out1_ready  input  1  consumer 1 takes the head entry.
out1_data  output  WIDTH  out1 FIFO head entry.
cnt0  output  $clog2(DEPTH)+1  out0 occupancy.
cnt1  output  $clog2(DEPTH)+1  out1 occupancy.

Behaviour:
- Reset:
  - reset_n low clears both FIFOs immediately, without waiting for clk: pointers 0, cnt0 = cnt1 = 0, out0_valid = out1_valid = 0.
  - in_ready = 0 while reset_n is low.
  - Reset asserted mid-operation discards all buffered beats.
  - First acceptance can occur on the first clk edge after reset_n rises.
- Input handshake:
  - in_ready = reset_n & ~full[in_sel]. This is combinational from in_sel only, with no path from out*_ready.
  - A beat transfers on a rising edge when in_valid & in_ready.
  - in_sel and in_data are sampled only on a transfer.
  - A beat whose in_sel targets a full FIFO stalls (in_ready = 0) even if the other FIFO has room. No reordering and no bypass.
- Latency:
  - An accepted beat is written at the edge.
  - From that edge, outN_valid = 1 and cntN is incremented; the beat is at the head if the FIFO was empty.
  - Minimum latency is 1 cycle. There is no combinational in-to-out path.
- Output handshake:
  - Head entry pops on a rising edge when outN_valid & outN_ready.
  - outN_ready while empty is ignored: no count change, no pointer move.
- Data when empty:
  - outN_data while outN_valid = 0 is unspecified. The bench must not check it.
- Simultaneous push and pop on the same FIFO:
  - Not full and not empty: both occur, cnt unchanged, order preserved.
  - Full: the push is refused because in_ready = 0 from full; the pop proceeds and cnt decrements. The push may be accepted next cycle.
  - Empty: the pop is ignored and the push is written.
- Pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - full = (cnt == DEPTH), empty = (cnt == 0).
  - cnt never exceeds DEPTH and never underflows.
- Ordering:
  - Per-output FIFO order equals acceptance order of the beats with that sel.
  - The two outputs are independent: a push to one and a pop from the other may occur in the same cycle.

Test Plan:
- Reset then route: release reset, send 16'hbeef sel 0. Next cycle out0_valid = 1, out0_data = beef, cnt0 = 1; out1_valid = 0.
- Alternate select: send dead sel 1 then abcd sel 0 with out0_ready = 0 and out1_ready = 1.
  - out1 shows dead for exactly one cycle, then out1_valid = 0.
  - out0 holds beef then abcd in order; cnt0 = 2.
- Full stall:
  - Setup: out0 holding 2 entries, out0_ready = 0, in_valid = 1, in_sel = 0, in_data = 1234.
  - Expect in_ready = 0 and no change in cnt0.
  - Set in_sel = 1: in_ready = 1 and 1234 lands in out1.
- Full with pop:
  - Setup: out0 full (beef, abcd), out0_ready = 1, push 5555 sel 0 held valid.
  - Cycle 1: pop beef, push refused, cnt0 = 1.
  - Cycle 2: 5555 accepted.
  - Final out0 order: abcd, 5555.
- Wrap-around: stream 0001..0008 through out0 with out0_ready toggling every cycle. All 8 values emerge in order; cnt0 stays ≤ 2.
- Async reset mid-stream:
  - Drop reset_n between clock edges with both FIFOs non-empty.
  - out*_valid, cnt* and in_ready go 0 immediately.
  - After release, the first beat sent emerges with no stale data ahead of it.
